fifo_rr_arbiter: RTL and testbench

//  Downstream stage of the 6-bit input FIFO bank. Pops words from NUM_Q upstream

---
 rtl/fifo_rr_arbiter_pkg.sv | 29 ++
 rtl/fifo_rr_arbiter_rr_pick.sv | 39 +++
 rtl/fifo_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// rtl/fifo_rr_arbiter_pkg.sv - shared types and constants for the round-robin FIFO arbiter
package fifo_rr_arbiter_pkg;

    // Default word width of the upstream FIFO bank.
    localparam int DATA_W_DEF = 6;

    // Upper limit on queue count; queue indices are always carried in IDX_W bits.
    localparam int MAX_Q = 8;
    localparam int IDX_W = 3;

    // The top CLASS_W bits of every word are the class field, forwarded untouched.
    localparam int CLASS_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2,
        ST_ERROR  = 2'd3
    } arb_state_t;

    // Next round-robin start position after serving queue idx out of n queues.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rtl/fifo_rr_arbiter_rr_pick.sv - rotate-priority encoder picking the first requester at or after ptr
module fifo_rr_arbiter_rr_pick
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int NUM_Q = 4
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_Q-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    localparam int SUM_W = IDX_W + 1;

    logic [NUM_Q-1:0] req_rot;
    logic [SUM_W-1:0] sum;

    // Rotate the request vector so bit 0 is the queue at ptr, take the lowest set
    // bit, then map that position back to an absolute queue index.
    always_comb begin
        req_rot = NUM_Q'({req, req} >> ptr);
        any     = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            if (!any && req_rot[k]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + SUM_W'(k);
                if (sum >= SUM_W'(NUM_Q)) begin
                    sum = sum - SUM_W'(NUM_Q);
                end
                gnt_idx = sum[IDX_W-1:0];
            end
        end
        gnt = any ? (NUM_Q'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin pop arbiter serialising NUM_Q upstream FIFOs into one stream
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int NUM_Q   = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_DST = 4
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic [NUM_Q-1:0]        q_empty,
    input  logic [NUM_Q*DATA_W-1:0] q_data,
    input  logic [NUM_Q-1:0]        q_err,
    input  logic [NUM_DST-1:0]      dst_afull,
    output logic [NUM_Q-1:0]        q_rd,
    output logic                    push,
    output logic [DATA_W-1:0]       data_out,
    output logic [2:0]              src_id,
    output logic [1:0]              state,
    output logic                    err_latched
);

    localparam int CLS_HI = DATA_W - 1;
    localparam int CLS_LO = DATA_W - CLASS_W;

    arb_state_t        state_r;
    arb_state_t        state_nxt;
    logic [IDX_W-1:0]  rr_ptr;

    logic [NUM_Q-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              grant_en;

    logic              err_any;
    logic              afull_any;

    // Stage 1: a queue was popped last cycle; its word is on q_data this cycle.
    logic              s1_valid;
    logic [IDX_W-1:0]  s1_idx;

    logic [DATA_W-1:0] q_word [MAX_Q];
    logic [DATA_W-1:0] sel_word;

    assign err_any   = |q_err;
    assign afull_any = |dst_afull;

    // Unpack the flat data bus; unused slots read as zero so any IDX_W index is legal.
    for (genvar g = 0; g < MAX_Q; g++) begin : g_word
        if (g < NUM_Q) begin : g_live
            assign q_word[g] = q_data[g*DATA_W +: DATA_W];
        end else begin : g_pad
            assign q_word[g] = '0;
        end
    end

    assign sel_word = q_word[s1_idx];

    // A queue whose empty flag rose from its own pop drops out of req here, so it
    // cannot be granted again on stale occupancy.
    fifo_rr_arbiter_rr_pick #(
        .NUM_Q (NUM_Q)
    ) u_pick (
        .req     (~q_empty),
        .ptr     (rr_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Next-state and grant enable; error outranks backpressure, which outranks granting.
    always_comb begin
        state_nxt = state_r;
        grant_en  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (err_any) begin
                    state_nxt = ST_ERROR;
                end else if (pick_any) begin
                    state_nxt = afull_any ? ST_STALL : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (err_any) begin
                    state_nxt = ST_ERROR;
                end else if (afull_any) begin
                    state_nxt = ST_STALL;
                end else begin
                    grant_en = pick_any;
                    if (!pick_any && !s1_valid) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_STALL: begin
                if (err_any) begin
                    state_nxt = ST_ERROR;
                end else if (!afull_any) begin
                    state_nxt = (pick_any || s1_valid) ? ST_ACTIVE : ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign q_rd  = grant_en ? pick_gnt : '0;
    assign state = state_r;

    // State register and round-robin pointer, which advances past every served queue.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            rr_ptr  <= '0;
        end else begin
            state_r <= state_nxt;
            if (grant_en) begin
                rr_ptr <= wrap_inc(pick_idx, NUM_Q);
            end
        end
    end

    // Two-stage pop-to-push pipeline; an error kills every word not yet on the output.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            push     <= 1'b0;
            data_out <= '0;
            src_id   <= '0;
        end else if (err_any || state_r == ST_ERROR) begin
            s1_valid <= 1'b0;
            push     <= 1'b0;
        end else begin
            s1_valid <= grant_en;
            if (grant_en) begin
                s1_idx <= pick_idx;
            end
            push <= s1_valid;
            if (s1_valid) begin
                data_out <= {sel_word[CLS_HI:CLS_LO], sel_word[CLS_LO-1:0]};
                src_id   <= s1_idx;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            err_latched <= 1'b0;
        end else if (err_any) begin
            err_latched <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - randomized self-checking bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;

    localparam int NQ = 4;
    localparam int DW = 6;
    localparam int ND = 4;

    logic             clk = 1'b0;
    logic             RESET;
    logic [NQ-1:0]    q_empty;
    logic [NQ*DW-1:0] q_data;
    logic [NQ-1:0]    q_err;
    logic [ND-1:0]    dst_afull;
    logic [NQ-1:0]    q_rd;
    logic             push;
    logic [DW-1:0]    data_out;
    logic [2:0]       src_id;
    logic [1:0]       state;
    logic             err_latched;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(
        .NUM_Q   (NQ),
        .DATA_W  (DW),
        .NUM_DST (ND)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .q_empty     (q_empty),
        .q_data      (q_data),
        .q_err       (q_err),
        .dst_afull   (dst_afull),
        .q_rd        (q_rd),
        .push        (push),
        .data_out    (data_out),
        .src_id      (src_id),
        .state       (state),
        .err_latched (err_latched)
    );

    typedef struct {
        int cyc;
        int word;
        int src;
    } sched_t;

    int n_vec = 0;
    int n_bad = 0;

    // Upstream FIFO environment: contents plus registered read-data per queue.
    logic [DW-1:0] fq [NQ][$];
    logic [DW-1:0] out_reg [NQ];

    // Reference model: words promised to the output, keyed by the cycle they appear.
    sched_t sched [$];
    int     m_state;
    int     m_ptr;
    bit     m_err;
    int     cyc;

    bit            chk_en;
    bit            rst_req;
    logic [NQ-1:0] err_req;
    int            p_fill;
    int            p_afull;
    bit            afull_rand;
    logic [ND-1:0] afull_force;

    bit            cur_rst;
    logic [NQ-1:0] cur_err;
    logic [NQ-1:0] cur_req;
    logic [ND-1:0] cur_afull;

    logic [NQ-1:0] exp_rd;
    bit            exp_push;
    int            exp_data;
    int            exp_src;
    bit            exp_zero;
    int            exp_g;
    int            g_word;

    logic [NQ-1:0] dut_rd;
    int            gnt_log [$];
    int            push_cnt;
    int            last_data;
    int            last_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_err   = 1'b0;
        sched.delete();
    endtask

    // Advance the model across a rising edge using the inputs of the cycle just ended.
    task automatic model_edge();
        bit inflight;
        bit afull;
        bit anyq;
        int nxt;
        sched_t s;
        if (cur_rst) begin
            model_reset();
        end else begin
            inflight = 1'b0;
            for (int k = 0; k < sched.size(); k++) begin
                if (sched[k].cyc == cyc + 1) inflight = 1'b1;
            end
            afull = (cur_afull != 0);
            anyq  = (cur_req != 0);
            if (cur_err != 0) begin
                m_err = 1'b1;
                for (int k = sched.size() - 1; k >= 0; k--) begin
                    if (sched[k].cyc > cyc) sched.delete(k);
                end
            end
            if (exp_g >= 0) begin
                s.cyc  = cyc + 2;
                s.word = g_word;
                s.src  = exp_g;
                sched.push_back(s);
                m_ptr = (exp_g + 1) % NQ;
            end
            nxt = m_state;
            if (m_state == 3 || cur_err != 0) begin
                nxt = 3;
            end else if (m_state == 0) begin
                if (anyq) nxt = afull ? 2 : 1;
            end else if (m_state == 1) begin
                if (afull) nxt = 2;
                else if (!anyq && !inflight) nxt = 0;
            end else begin
                if (!afull) nxt = (anyq || inflight) ? 1 : 0;
            end
            m_state = nxt;
        end
        for (int k = sched.size() - 1; k >= 0; k--) begin
            if (sched[k].cyc <= cyc) sched.delete(k);
        end
    endtask

    // Drive this cycle's inputs and derive every expected output from the model.
    task automatic drive_and_expect();
        int qi;
        for (int i = 0; i < NQ; i++) begin
            if (p_fill > 0 && $urandom_range(0, 99) < p_fill && fq[i].size() < 6)
                fq[i].push_back(DW'($urandom));
        end
        RESET = rst_req;
        q_err = err_req;
        if (afull_rand)
            dst_afull = ($urandom_range(0, 99) < p_afull) ? ND'($urandom_range(1, 15)) : '0;
        else
            dst_afull = afull_force;
        for (int i = 0; i < NQ; i++) begin
            q_empty[i]            = (fq[i].size() == 0);
            q_data[i*DW +: DW]    = out_reg[i];
        end
        cur_rst   = rst_req;
        cur_err   = q_err;
        cur_afull = dst_afull;
        cur_req   = ~q_empty;
        if (rst_req) model_reset();
        exp_zero = rst_req;
        exp_g    = -1;
        g_word   = 0;
        if (m_state == 1 && cur_afull == 0 && cur_err == 0) begin
            for (int k = 0; k < NQ; k++) begin
                qi = (m_ptr + k) % NQ;
                if (exp_g < 0 && fq[qi].size() > 0) begin
                    exp_g  = qi;
                    g_word = int'(fq[qi][0]);
                end
            end
        end
        exp_rd   = (exp_g >= 0) ? (NQ'(1) << exp_g) : '0;
        exp_push = 1'b0;
        exp_data = 0;
        exp_src  = 0;
        for (int k = 0; k < sched.size(); k++) begin
            if (sched[k].cyc == cyc) begin
                exp_push = 1'b1;
                exp_data = sched[k].word;
                exp_src  = sched[k].src;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        for (int i = 0; i < NQ; i++) begin
            if (dut_rd[i] && fq[i].size() > 0) out_reg[i] = fq[i].pop_front();
        end
        dut_rd = '0;
        cyc++;
        #1;
        drive_and_expect();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NQ; i++) begin
            fq[i].delete();
            out_reg[i] = '0;
        end
    endtask

    task automatic do_reset();
        clear_fifos();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        gnt_log.delete();
        push_cnt = 0;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("q_rd", 32'(q_rd), 32'(exp_rd));
            chk("rd_on_empty", 32'(q_rd & q_empty), 0);
            chk("rd_onehot", 32'($countones(q_rd) <= 1), 1);
            chk("push", 32'(push), 32'(exp_push));
            if (exp_push) begin
                chk("data_out", 32'(data_out), exp_data);
                chk("src_id", 32'(src_id), exp_src);
            end
            if (exp_zero) begin
                chk("rst_data_out", 32'(data_out), 0);
                chk("rst_src_id", 32'(src_id), 0);
            end
            chk("state", 32'(state), m_state);
            chk("err_latched", 32'(err_latched), 32'(m_err));
            for (int i = 0; i < NQ; i++) begin
                if (q_rd[i]) gnt_log.push_back(i);
            end
            if (push) begin
                push_cnt++;
                last_data = int'(data_out);
                last_src  = int'(src_id);
            end
            dut_rd = q_rd;
        end
    end

    initial begin
        int exp_b1 [8];
        int exp_b2 [4];
        int exp_f [3];
        exp_b1 = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_b2 = '{1, 3, 1, 3};
        exp_f  = '{0, 2, 0};

        RESET = 1'b1; q_empty = '1; q_data = '0; q_err = '0; dst_afull = '0;
        rst_req = 1'b1; err_req = '0; p_fill = 0; p_afull = 0;
        afull_rand = 1'b0; afull_force = '0;
        cur_rst = 1'b1; cur_err = '0; cur_req = '0; cur_afull = '0;
        exp_g = -1; g_word = 0; dut_rd = '0; cyc = 0;
        push_cnt = 0; last_data = 0; last_src = 0;
        model_reset();
        clear_fifos();
        chk_en = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_state", 32'(state), 0);
        chk("rst_push", 32'(push), 0);
        chk("rst_q_rd", 32'(q_rd), 0);
        chk("rst_err", 32'(err_latched), 0);

        // Single source: three 6'h2A words in queue 0
        rst_req = 1'b0;
        gnt_log.delete(); push_cnt = 0;
        repeat (3) fq[0].push_back(6'h2A);
        step();
        step();
        chk("A_first_rd", 32'(q_rd), 1);
        repeat (8) step();
        chk("A_grants", gnt_log.size(), 3);
        chk("A_pushes", push_cnt, 3);
        chk("A_data", last_data, 42);
        chk("A_src", last_src, 0);
        chk("A_idle", 32'(state), 0);

        // Round robin over all four queues from pointer 0
        do_reset();
        for (int i = 0; i < NQ; i++) repeat (4) fq[i].push_back(DW'($urandom));
        repeat (24) step();
        chk("B1_count", gnt_log.size(), 16);
        for (int k = 0; k < 8; k++)
            chk("B1_order", (k < gnt_log.size()) ? gnt_log[k] : -1, exp_b1[k]);

        // Round robin with only queues 1 and 3 occupied
        do_reset();
        repeat (2) fq[1].push_back(DW'($urandom));
        repeat (2) fq[3].push_back(DW'($urandom));
        repeat (10) step();
        chk("B2_count", gnt_log.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("B2_order", (k < gnt_log.size()) ? gnt_log[k] : -1, exp_b2[k]);

        // Backpressure while active
        do_reset();
        for (int i = 0; i < NQ; i++) repeat (5) fq[i].push_back(DW'($urandom));
        repeat (3) step();
        afull_force = 4'b0100;
        push_cnt = 0;
        step();
        chk("C_no_rd", 32'(q_rd), 0);
        step();
        chk("C_stall", 32'(state), 2);
        repeat (2) step();
        chk("C_inflight", push_cnt, 2);
        afull_force = '0;
        repeat (30) step();
        chk("C_drained", gnt_log.size(), 20);

        // Randomized traffic with random backpressure and a mid-run reset
        do_reset();
        p_fill = 35; afull_rand = 1'b1; p_afull = 10;
        repeat (1500) step();
        afull_rand = 1'b0; p_fill = 60;
        repeat (5) step();
        rst_req = 1'b1;
        step();
        chk("D_rst_push", 32'(push), 0);
        chk("D_rst_state", 32'(state), 0);
        chk("D_rst_rd", 32'(q_rd), 0);
        rst_req = 1'b0;
        step();
        chk("D_no_push", 32'(push), 0);
        afull_rand = 1'b1;
        repeat (1500) step();
        afull_rand = 1'b0; p_fill = 0;

        // Error on queue 1
        do_reset();
        for (int i = 0; i < NQ; i++) repeat (5) fq[i].push_back(DW'($urandom));
        repeat (3) step();
        err_req = 4'b0010;
        step();
        err_req = '0;
        push_cnt = 0; gnt_log.delete();
        step();
        chk("E_state", 32'(state), 3);
        chk("E_err", 32'(err_latched), 1);
        repeat (4) step();
        chk("E_pushes", push_cnt, 0);
        chk("E_grants", gnt_log.size(), 0);
        chk("E_sticky", 32'(err_latched), 1);

        // Drain: three words across queues 0 and 2
        do_reset();
        fq[0].push_back(6'h11);
        fq[0].push_back(6'h22);
        fq[2].push_back(6'h3F);
        repeat (12) step();
        chk("F_pushes", push_cnt, 3);
        chk("F_idle", 32'(state), 0);
        chk("F_count", gnt_log.size(), 3);
        for (int k = 0; k < 3; k++)
            chk("F_order", (k < gnt_log.size()) ? gnt_log[k] : -1, exp_f[k]);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
